// File: rtl/vticket_tracker.sv
// Completion side of the vector ticket protocol: tracks issued tickets as pending
// until a writeback port retires them, and answers producer-done queries.
module vticket_tracker #(
    parameter int VECTOR_TICKET_BITS = 4,
    parameter int NUM_WB_PORTS       = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       alloc_valid_i,
    input  logic [VECTOR_TICKET_BITS-1:0]              alloc_ticket_i,
    output logic                                       alloc_ready_o,
    input  logic                                       reconfig_valid_i,
    output logic                                       reconfig_ready_o,
    input  logic [NUM_WB_PORTS-1:0]                    wb_valid_i,
    input  logic [NUM_WB_PORTS*VECTOR_TICKET_BITS-1:0] wb_ticket_i,
    input  logic [VECTOR_TICKET_BITS-1:0]              query_ticket1_i,
    input  logic [VECTOR_TICKET_BITS-1:0]              query_ticket2_i,
    output logic                                       query_done1_o,
    output logic                                       query_done2_o,
    output logic [VECTOR_TICKET_BITS-1:0]              head_ticket_o,
    output logic [VECTOR_TICKET_BITS-1:0]              outstanding_o,
    output logic                                       is_idle_o,
    output logic                                       error_o
);

    localparam int              T     = VECTOR_TICKET_BITS;
    localparam int              N     = 1 << T;
    localparam logic [T-1:0]    ZERO  = {T{1'b0}};
    localparam logic [T-1:0]    ONE   = {{(T-1){1'b0}}, 1'b1};
    localparam logic [T-1:0]    LAST  = {T{1'b1}};
    localparam logic [N-1:0]    BIT0  = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] r_pending;
    logic [T-1:0] r_next_alloc;
    logic [T-1:0] r_head;
    logic [T-1:0] r_outstanding;
    logic         r_error;

    logic         w_alloc_fire;
    logic         w_alloc_err;
    logic         w_reconfig_fire;
    logic         w_head_step;
    logic         w_set_new;
    logic         w_wb_err;
    logic [N-1:0] w_set_mask;
    logic [N-1:0] w_clr_mask;
    logic [N-1:0] w_pending_nxt;
    logic [T-1:0] w_clr_cnt;

    // A ticket is done if never issued (0), not pending, or retiring this very cycle.
    function automatic logic query_done(
        input logic [N-1:0]                   pending,
        input logic [NUM_WB_PORTS-1:0]        wb_valid,
        input logic [NUM_WB_PORTS*T-1:0]      wb_ticket,
        input logic [T-1:0]                   ticket
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
            hit = hit | (wb_valid[k] & (wb_ticket[k*T +: T] == ticket));
        end
        return (ticket == ZERO) | ~pending[ticket] | hit;
    endfunction

    assign alloc_ready_o    = ~r_pending[r_next_alloc];
    assign reconfig_ready_o = (r_outstanding == ZERO) & ~alloc_valid_i;
    assign w_alloc_fire     = alloc_valid_i & alloc_ready_o;
    assign w_reconfig_fire  = reconfig_valid_i & reconfig_ready_o;
    assign w_alloc_err      = (alloc_valid_i & ~alloc_ready_o)
                            | (w_alloc_fire & ((alloc_ticket_i != r_next_alloc) | (alloc_ticket_i == ZERO)));
    assign w_head_step      = (r_head != r_next_alloc) & ~r_pending[r_head];
    assign w_set_new        = |(w_set_mask & ~r_pending);
    assign w_pending_nxt    = ((r_pending & ~w_clr_mask) | w_set_mask) & ~BIT0;

    assign query_done1_o    = query_done(r_pending, wb_valid_i, wb_ticket_i, query_ticket1_i);
    assign query_done2_o    = query_done(r_pending, wb_valid_i, wb_ticket_i, query_ticket2_i);
    assign head_ticket_o    = r_head;
    assign outstanding_o    = r_outstanding;
    assign is_idle_o        = (r_outstanding == ZERO);
    assign error_o          = r_error;

    // Build set/clear masks; a later port repeating an earlier port's ticket is a duplicate.
    always_comb begin
        logic [T-1:0] w_tk;
        logic         w_dup;
        logic         w_ok;
        w_set_mask = {N{1'b0}};
        w_clr_mask = {N{1'b0}};
        w_wb_err   = 1'b0;
        w_clr_cnt  = ZERO;
        w_tk       = ZERO;
        w_dup      = 1'b0;
        w_ok       = 1'b0;
        w_set_mask = (w_alloc_fire & (alloc_ticket_i != ZERO)) ? (BIT0 << alloc_ticket_i) : {N{1'b0}};
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
            w_tk  = wb_ticket_i[k*T +: T];
            w_dup = 1'b0;
            for (int j = 0; j < k; j++) begin
                w_dup = w_dup | (wb_valid_i[j] & (wb_ticket_i[j*T +: T] == w_tk));
            end
            w_ok       = wb_valid_i[k] & (w_tk != ZERO) & r_pending[w_tk] & ~w_set_mask[w_tk] & ~w_dup;
            w_wb_err   = w_wb_err | (wb_valid_i[k] & ~w_ok);
            w_clr_mask = w_clr_mask | (w_ok ? (BIT0 << w_tk) : {N{1'b0}});
            w_clr_cnt  = w_clr_cnt + (w_ok ? ONE : ZERO);
        end
    end

    // Tracker state: pending bitmap, allocation/head pointers, occupancy and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending     <= {N{1'b0}};
            r_next_alloc  <= ONE;
            r_head        <= ONE;
            r_outstanding <= ZERO;
            r_error       <= 1'b0;
        end else begin
            r_pending     <= w_pending_nxt;
            r_outstanding <= r_outstanding + (w_set_new ? ONE : ZERO) - w_clr_cnt;
            r_error       <= r_error | w_alloc_err | w_wb_err;
            if (w_reconfig_fire) begin
                r_next_alloc <= ONE;
                r_head       <= ONE;
            end else begin
                if (w_alloc_fire) begin
                    r_next_alloc <= (r_next_alloc == LAST) ? ONE : r_next_alloc + ONE;
                end else begin
                    r_next_alloc <= r_next_alloc;
                end
                if (w_head_step) begin
                    r_head <= (r_head == LAST) ? ONE : r_head + ONE;
                end else begin
                    r_head <= r_head;
                end
            end
        end
    end

endmodule

// File: tb/tb_vticket_tracker.sv
// Self-checking bench for vticket_tracker: directed scenarios followed by random
// traffic, all compared against a ticket-set reference model.
module tb_vticket_tracker;

    localparam int T = 4;
    localparam int P = 2;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           alloc_valid_i;
    logic [T-1:0]   alloc_ticket_i;
    logic           alloc_ready_o;
    logic           reconfig_valid_i;
    logic           reconfig_ready_o;
    logic [P-1:0]   wb_valid_i;
    logic [P*T-1:0] wb_ticket_i;
    logic [T-1:0]   query_ticket1_i;
    logic [T-1:0]   query_ticket2_i;
    logic           query_done1_o;
    logic           query_done2_o;
    logic [T-1:0]   head_ticket_o;
    logic [T-1:0]   outstanding_o;
    logic           is_idle_o;
    logic           error_o;

    int n_checks = 0;
    int n_errors = 0;

    bit m_pend [N];
    int m_na;
    int m_head;
    bit m_err;

    always #5 clk = ~clk;

    vticket_tracker #(.VECTOR_TICKET_BITS(T), .NUM_WB_PORTS(P)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .alloc_valid_i    (alloc_valid_i),
        .alloc_ticket_i   (alloc_ticket_i),
        .alloc_ready_o    (alloc_ready_o),
        .reconfig_valid_i (reconfig_valid_i),
        .reconfig_ready_o (reconfig_ready_o),
        .wb_valid_i       (wb_valid_i),
        .wb_ticket_i      (wb_ticket_i),
        .query_ticket1_i  (query_ticket1_i),
        .query_ticket2_i  (query_ticket2_i),
        .query_done1_o    (query_done1_o),
        .query_done2_o    (query_done2_o),
        .head_ticket_o    (head_ticket_o),
        .outstanding_o    (outstanding_o),
        .is_idle_o        (is_idle_o),
        .error_o          (error_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int wrap_inc(input int v);
        return (v == N - 1) ? 1 : v + 1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_pend[i];
        return c;
    endfunction

    function automatic bit m_qdone(input int t);
        bit hit = 0;
        for (int k = 0; k < P; k++)
            if (wb_valid_i[k] && int'(wb_ticket_i[k*T +: T]) == t) hit = 1;
        return (t == 0) || !m_pend[t] || hit;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_na = 1; m_head = 1; m_err = 0;
    endtask

    // Apply one clock edge of the protocol rules to the reference ticket set.
    task automatic model_update();
        bit np [N];
        bit seen [N];
        int nna, nhead, setv, t, cnt;
        bit e;
        if (rst_i) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin np[i] = m_pend[i]; seen[i] = 0; end
        nna = m_na; nhead = m_head; e = 0; setv = -1; cnt = m_count();
        if (alloc_valid_i) begin
            if (m_pend[m_na]) e = 1;
            else begin
                if (int'(alloc_ticket_i) != m_na) e = 1;
                if (alloc_ticket_i != 0) begin
                    np[alloc_ticket_i] = 1;
                    setv = int'(alloc_ticket_i);
                end
                nna = wrap_inc(m_na);
            end
        end
        for (int k = 0; k < P; k++) begin
            if (wb_valid_i[k]) begin
                t = int'(wb_ticket_i[k*T +: T]);
                if (t == 0 || !m_pend[t] || t == setv || seen[t]) e = 1;
                else np[t] = 0;
                seen[t] = 1;
            end
        end
        if (m_head != m_na && !m_pend[m_head]) nhead = wrap_inc(m_head);
        if (reconfig_valid_i && cnt == 0 && !alloc_valid_i) begin
            nna = 1; nhead = 1;
        end
        for (int i = 0; i < N; i++) m_pend[i] = np[i];
        m_na = nna; m_head = nhead; m_err = m_err | e;
    endtask

    task automatic check_comb();
        check_val("alloc_ready", alloc_ready_o, !m_pend[m_na]);
        check_val("reconfig_ready", reconfig_ready_o, (m_count() == 0) && !alloc_valid_i);
        check_val("query1", query_done1_o, m_qdone(int'(query_ticket1_i)));
        check_val("query2", query_done2_o, m_qdone(int'(query_ticket2_i)));
    endtask

    task automatic check_regs();
        check_val("head", head_ticket_o, m_head);
        check_val("outstanding", outstanding_o, m_count());
        check_val("idle", is_idle_o, m_count() == 0);
        check_val("error", error_o, m_err);
    endtask

    task automatic step();
        #1;
        check_comb();
        model_update();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle_inputs();
        rst_i = 0; alloc_valid_i = 0; alloc_ticket_i = 0; reconfig_valid_i = 0;
        wb_valid_i = 0; wb_ticket_i = 0; query_ticket1_i = 0; query_ticket2_i = 0;
    endtask

    task automatic alloc(input int t);
        alloc_valid_i = 1; alloc_ticket_i = T'(t);
        step();
        alloc_valid_i = 0; alloc_ticket_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        step();
        rst_i = 0;
    endtask

    initial begin
        int q[$];
        int r;
        idle_inputs();
        rst_i = 1;
        @(posedge clk);
        #1;
        model_reset();
        rst_i = 0;
        #1;
        check_val("rst_alloc_ready", alloc_ready_o, 1);
        check_val("rst_reconfig_ready", reconfig_ready_o, 1);
        check_val("rst_head", head_ticket_o, 1);
        check_val("rst_outstanding", outstanding_o, 0);
        check_val("rst_idle", is_idle_o, 1);
        check_val("rst_error", error_o, 0);

        // Three back-to-back allocations
        for (int t = 1; t <= 3; t++) alloc(t);
        query_ticket1_i = 2; query_ticket2_i = 0;
        #1;
        check_val("t1_outstanding", outstanding_o, 3);
        check_val("t1_head", head_ticket_o, 1);
        check_val("t1_q2pending", query_done1_o, 0);
        check_val("t1_q0done", query_done2_o, 1);
        step();

        // Out-of-order completion with same-cycle query bypass
        wb_valid_i = 2'b01; wb_ticket_i = {4'd0, 4'd2};
        #1;
        check_val("t2_bypass", query_done1_o, 1);
        step();
        check_val("t2_out_a", outstanding_o, 2);
        wb_valid_i = 2'b10; wb_ticket_i = {4'd1, 4'd0};
        step();
        check_val("t2_out_b", outstanding_o, 1);
        wb_valid_i = 0; wb_ticket_i = 0;
        step(); step(); step();
        check_val("t2_head", head_ticket_o, 3);

        // Full ticket space, wrap back to ticket 1
        do_reset();
        for (int t = 1; t <= 15; t++) alloc(t);
        #1;
        check_val("t3_full_ready", alloc_ready_o, 0);
        wb_valid_i = 2'b01; wb_ticket_i = {4'd0, 4'd1};
        step();
        wb_valid_i = 0; wb_ticket_i = 0;
        #1;
        check_val("t3_ready_again", alloc_ready_o, 1);
        alloc(1);
        check_val("t3_err", error_o, 0);
        check_val("t3_out", outstanding_o, 15);

        // Dual-port completion, then a duplicate
        wb_valid_i = 2'b11; wb_ticket_i = {4'd5, 4'd4};
        step();
        check_val("t4_out_a", outstanding_o, 13);
        wb_ticket_i = {4'd4, 4'd3};
        step();
        wb_valid_i = 0; wb_ticket_i = 0;
        check_val("t4_out_b", outstanding_o, 12);
        check_val("t4_err", error_o, 1);

        // Reconfiguration held off until drained
        do_reset();
        alloc(1); alloc(2);
        reconfig_valid_i = 1;
        #1;
        check_val("t5_rc_blocked", reconfig_ready_o, 0);
        step();
        wb_valid_i = 2'b11; wb_ticket_i = {4'd2, 4'd1};
        step();
        wb_valid_i = 0; wb_ticket_i = 0;
        #1;
        check_val("t5_rc_ready", reconfig_ready_o, 1);
        step();
        reconfig_valid_i = 0;
        #1;
        check_val("t5_after_rc_ready", alloc_ready_o, 1);
        alloc(1);
        check_val("t5_err", error_o, 0);
        check_val("t5_out", outstanding_o, 1);

        // Wrong ticket, sticky error, reset mid-stream
        do_reset();
        alloc(3);
        check_val("t6_err", error_o, 1);
        step();
        check_val("t6_sticky", error_o, 1);
        alloc(2);
        wb_valid_i = 2'b01; wb_ticket_i = {4'd0, 4'd3};
        step();
        wb_valid_i = 0; wb_ticket_i = 0;
        for (int t = 3; t <= 6; t++) alloc(t);
        check_val("t6_out5", outstanding_o, 5);
        do_reset();
        check_val("t6_rst_out", outstanding_o, 0);
        check_val("t6_rst_err", error_o, 0);
        check_val("t6_rst_ready", alloc_ready_o, 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            alloc_valid_i = ($urandom_range(0, 1) == 1) && (!m_pend[m_na] || $urandom_range(0, 7) == 0);
            alloc_ticket_i = ($urandom_range(0, 19) == 0) ? T'($urandom_range(0, 15)) : T'(m_na);
            reconfig_valid_i = ($urandom_range(0, 9) == 0);
            q.delete();
            for (int i = 1; i < N; i++) if (m_pend[i]) q.push_back(i);
            for (int k = 0; k < P; k++) begin
                wb_valid_i[k] = ($urandom_range(0, 9) < 4);
                if (q.size() > 0 && $urandom_range(0, 14) != 0) r = q[$urandom_range(0, q.size() - 1)];
                else r = $urandom_range(0, 15);
                wb_ticket_i[k*T +: T] = T'(r);
            end
            query_ticket1_i = T'($urandom_range(0, 15));
            query_ticket2_i = T'($urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
